exm_alu: RTL and testbench
==========================

EXM_ALU -- requirements
Module: exm_alu

Interface
REQ-001 Parameter: DATA_W, default 32, datapath width; all requirements below are stated for 32.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operands and select valid this cycle.
REQ-005 A  input  32  operand A (rs1/PC).
REQ-006 B  input  32  operand B (rs2/immediate).
REQ-007 ALUSel  input  4  operation select.
REQ-008 alu  output  32  registered result.
REQ-009 out_valid  output  1  alu holds a new result.
REQ-010 zero  output  1  registered; 1 when alu == 0.

Function
REQ-011 ALUSel encoding SHALL be:
- 0 ADD: A+B mod 2^32.
- 1 SUB: A-B mod 2^32.
- 2 SLL: A << B[4:0].
- 3 SLT: 1 if signed A < signed B, else 0.
- 4 SLTU: 1 if unsigned A < unsigned B, else 0.
- 5 XOR: A ^ B.
- 6 SRL: A >> B[4:0], logical.
- 7 SRA: A >> B[4:0], arithmetic, sign-filled.
- 8 OR: A | B.
- 9 AND: A & B.
- 0xA PASSB: B (LUI).
- 0xB PASSA: A.
- 0xC LINK: A+4 mod 2^32.
REQ-012 ALUSel 0xD-0xF SHALL produce 0x00000000; they are not errors.
REQ-013 Shift amount SHALL be B[4:0] only; B[31:5] SHALL be ignored.
REQ-014 SLT/SLTU results SHALL be zero-extended to 32 bits.
REQ-015 Overflow and carry SHALL be discarded; no flag output exists for them.
REQ-016 Latency SHALL be 1 cycle: inputs sampled at a rising edge with in_valid=1 appear on alu/zero after that edge.
REQ-017 out_valid SHALL equal in_valid delayed by one cycle.
REQ-018 When in_valid=0 at a rising edge, alu and zero SHALL hold their previous values.
REQ-019 Back-to-back valid inputs SHALL give one result per cycle, with no bubbles and no stalls.
REQ-020 zero SHALL be computed from the same result that is registered into alu.

Reset
REQ-021 Asserting rst_n=0 SHALL immediately clear alu=0, zero=0 and out_valid=0, regardless of clk.
REQ-022 While rst_n=0, inputs SHALL be ignored.
REQ-023 The first capture after reset SHALL occur at the first rising edge with rst_n=1.
REQ-024 Reset asserted mid-stream SHALL discard the in-flight result.

Verification
REQ-025 A=0x00001234, B=0xFFFFFFFD, in_valid=1, ALUSel 0/1/2/3/4 -> alu 0x00001231 / 0x00001237 / 0x80000000 / 0x00000000 (zero=1) / 0x00000001.
REQ-026 A=0xFFFFFFFC, B=0xFFFFFFFD, ALUSel 5/6/7 -> alu 0x00000001 / 0x00000007 / 0xFFFFFFFF.
REQ-027 A=0x12344567, B=0xFFFFFFFD, ALUSel 8/9/A/B/C/F -> alu 0xFFFFFFFF / 0x12344565 / 0xFFFFFFFD / 0x12344567 / 0x1234456B / 0x00000000.
REQ-028 in_valid pattern 1,1,0,1 -> out_valid 1,1,0,1 one cycle later; alu holds across the 0 cycle.
REQ-029 rst_n pulsed low between clock edges while out_valid=1 -> alu=0, zero=0, out_valid=0 immediately, before the next edge.
REQ-030 ADD with A=0xFFFFFFFF, B=0x00000001 -> alu 0x00000000, zero=1 (wrap-around).

Source files
------------

// File: rtl/exm_alu.sv
// Single-stage registered ALU: RV32-style ops on A/B selected by ALUSel, result and zero flag registered.
// Latency 1 cycle; accepts one operation per cycle and never stalls (no backpressure).
module exm_alu #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [3:0]        ALUSel,
    output logic [DATA_W-1:0] alu,
    output logic              out_valid,
    output logic              zero
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] result;
    logic [SH_W-1:0]   shamt;
    logic              lt_s;
    logic              lt_u;

    logic [DATA_W-1:0] alu_q, alu_d;
    logic              zero_q, zero_d;
    logic              vld_q, vld_d;

    assign shamt = B[SH_W-1:0];
    assign lt_s  = $signed(A) < $signed(B);
    assign lt_u  = A < B;

    always_comb begin
        result = '0;
        unique case (ALUSel)
            4'h0: result = A + B;
            4'h1: result = A - B;
            4'h2: result = A << shamt;
            4'h3: result = {{(DATA_W-1){1'b0}}, lt_s};
            4'h4: result = {{(DATA_W-1){1'b0}}, lt_u};
            4'h5: result = A ^ B;
            4'h6: result = A >> shamt;
            4'h7: result = $signed(A) >>> shamt;
            4'h8: result = A | B;
            4'h9: result = A & B;
            4'hA: result = B;
            4'hB: result = A;
            4'hC: result = A + DATA_W'(4);
            default: result = '0;
        endcase
    end

    // alu/zero hold their last value on idle cycles; both come from the same result.
    always_comb begin
        alu_d  = alu_q;
        zero_d = zero_q;
        vld_d  = in_valid;
        if (in_valid) begin
            alu_d  = result;
            zero_d = (result == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q  <= '0;
            zero_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            alu_q  <= alu_d;
            zero_q <= zero_d;
            vld_q  <= vld_d;
        end
    end

    assign alu       = alu_q;
    assign zero      = zero_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_exm_alu.sv
// Scoreboard bench for exm_alu: stimulus pushes expected per-cycle outputs, a monitor pops and compares.
module tb_exm_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUSel;
    logic [31:0] alu;
    logic        out_valid;
    logic        zero;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        vld;
        logic [31:0] res;
        logic        z;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] last_alu;
    logic        last_zero;

    exm_alu #(.DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .ALUSel   (ALUSel),
        .alu      (alu),
        .out_valid(out_valid),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: arithmetic from the operation definitions.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
        int unsigned sh;
        logic [31:0] fill;
        sh = b % 32;
        case (sel)
            4'h0: return a + b;
            4'h1: return a + (~b + 32'd1);
            4'h2: return a * (32'd1 << sh);
            4'h3: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'h4: return (a < b) ? 32'd1 : 32'd0;
            4'h5: return a ^ b;
            4'h6: return a / (32'd1 << sh);
            4'h7: begin
                fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                return (a >> sh) | fill;
            end
            4'h8: return a | b;
            4'h9: return a & b;
            4'hA: return b;
            4'hB: return a;
            4'hC: return a + 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        A        = a;
        B        = b;
        ALUSel   = sel;
        if (v) begin
            last_alu  = ref_alu(a, b, sel);
            last_zero = (last_alu == 32'd0);
        end
        e.vld = v;
        e.res = last_alu;
        e.z   = last_zero;
        exp_q.push_back(e);
    endtask

    // Spec'd golden values, checked directly against constants as well as the model.
    task automatic golden(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel, input logic [31:0] expv);
        check($sformatf("model_sel%0h", sel), ref_alu(a, b, sel), expv);
        step(1'b1, a, b, sel);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_valid", {31'd0, out_valid}, {31'd0, e.vld});
                check("alu", alu, e.res);
                check("zero", {31'd0, zero}, {31'd0, e.z});
            end
        end
    end

    initial begin : stim
        logic [31:0] a, b;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        A        = 32'h1234_5678;
        B        = 32'h0000_0001;
        ALUSel   = 4'h0;
        last_alu  = 32'd0;
        last_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_alu", alu, 32'd0);
        check("reset_zero", {31'd0, zero}, 32'd0);
        check("reset_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        golden(32'h0000_1234, 32'hFFFF_FFFD, 4'h0, 32'h0000_1231);
        golden(32'h0000_1234, 32'hFFFF_FFFD, 4'h1, 32'h0000_1237);
        golden(32'h0000_1234, 32'hFFFF_FFFD, 4'h2, 32'h8000_0000);
        golden(32'h0000_1234, 32'hFFFF_FFFD, 4'h3, 32'h0000_0000);
        golden(32'h0000_1234, 32'hFFFF_FFFD, 4'h4, 32'h0000_0001);
        golden(32'hFFFF_FFFC, 32'hFFFF_FFFD, 4'h5, 32'h0000_0001);
        golden(32'hFFFF_FFFC, 32'hFFFF_FFFD, 4'h6, 32'h0000_0007);
        golden(32'hFFFF_FFFC, 32'hFFFF_FFFD, 4'h7, 32'hFFFF_FFFF);
        golden(32'h1234_4567, 32'hFFFF_FFFD, 4'h8, 32'hFFFF_FFFF);
        golden(32'h1234_4567, 32'hFFFF_FFFD, 4'h9, 32'h1234_4565);
        golden(32'h1234_4567, 32'hFFFF_FFFD, 4'hA, 32'hFFFF_FFFD);
        golden(32'h1234_4567, 32'hFFFF_FFFD, 4'hB, 32'h1234_4567);
        golden(32'h1234_4567, 32'hFFFF_FFFD, 4'hC, 32'h1234_456B);
        golden(32'h1234_4567, 32'hFFFF_FFFD, 4'hF, 32'h0000_0000);
        golden(32'hFFFF_FFFF, 32'h0000_0001, 4'h0, 32'h0000_0000);

        // valid pattern 1,1,0,1 with hold across the gap
        step(1'b1, 32'h0000_0010, 32'h0000_0020, 4'h0);
        step(1'b1, 32'h0000_0030, 32'h0000_0003, 4'h1);
        step(1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 4'h0);
        step(1'b1, 32'h8000_0000, 32'h0000_0021, 4'h7);

        // reset pulsed between edges while out_valid=1, in-flight op discarded
        step(1'b1, 32'h0000_0005, 32'h0000_0006, 4'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_alu", alu, 32'd0);
        check("midrst_zero", {31'd0, zero}, 32'd0);
        check("midrst_vld", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        A = 32'h0000_0001;
        B = 32'h0000_0001;
        ALUSel = 4'h0;
        @(posedge clk);
        #1;
        check("rst_ignores_alu", alu, 32'd0);
        check("rst_ignores_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        last_alu  = 32'd0;
        last_zero = 1'b0;
        step(1'b0, 32'h0, 32'h0, 4'h0);
        step(1'b1, 32'h0000_0007, 32'h0000_0007, 4'h1);

        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: a = b;
                3: b = $urandom_range(0, 63);
                default: ;
            endcase
            step($urandom_range(0, 3) != 0, a, b, 4'($urandom_range(0, 15)));
        end
        step(1'b0, 32'h0, 32'h0, 4'h0);

        repeat (5) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
